// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: fetch-stage defaults and FSM state encoding shared with later stages.
package if_fetch_stage_pkg;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam int          DEF_CNT_W     = 16;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch control, instruction memory and IF/ID register signals.
interface if_fetch_stage_if #(parameter int CNT_W = if_fetch_stage_pkg::DEF_CNT_W);
    logic             le;
    logic             stall;
    logic             br_taken;
    logic [31:0]      br_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      pc_out;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic [CNT_W-1:0] fetch_count;
    modport master (
        input  le, stall, br_taken, br_target, imem_data,
        output imem_addr, pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );
    modport slave (
        output le, stall, br_taken, br_target, imem_data,
        input  imem_addr, pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// if_fetch_stage_pc_reg: word-aligned PC flop with target load and +4 advance.
module if_fetch_stage_pc_reg #(
    parameter logic [31:0] RESET_PC = if_fetch_stage_pkg::DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        load,
    input  logic [29:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc4
);
    assign pc4 = pc + 32'd4;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    pc <= {RESET_PC[31:2], 2'b00};
        else if (load) pc <= {target, 2'b00};
        else if (adv)  pc <= pc4;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC sequencing, IF/ID register, boot/run/hold FSM and fetch counter.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input logic             clk,
    input logic             rst_n,
    if_fetch_stage_if.master bus
);
    fetch_state_t state;
    logic         upd;
    logic [31:0]  pc4;
    // stall outranks a branch: the branching instruction is itself held in ID
    assign upd = (state == RUN) && bus.le && !bus.stall;
    assign bus.imem_addr = bus.pc_out;
    if_fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (upd && !bus.br_taken),
        .load   (upd && bus.br_taken),
        .target (bus.br_target[31:2]),
        .pc     (bus.pc_out),
        .pc4    (pc4)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state           <= BOOT;
            bus.ifid_instr  <= NOP_INSTR;
            bus.ifid_pc4    <= '0;
            bus.ifid_valid  <= 1'b0;
            bus.fetch_count <= '0;
        end else begin
            case (state)
                BOOT:    state <= bus.le ? RUN : BOOT;
                RUN:     state <= bus.le ? RUN : HOLD;
                default: state <= bus.le ? RUN : HOLD;
            endcase
            if (upd) begin
                bus.ifid_instr <= bus.br_taken ? NOP_INSTR : bus.imem_data;
                bus.ifid_pc4   <= bus.br_taken ? '0 : pc4;
                bus.ifid_valid <= !bus.br_taken;
                if (!bus.br_taken) bus.fetch_count <= bus.fetch_count + 1'b1;
            end
        end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table plus boot, hold and async-reset sequences.
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    if_fetch_stage_if #(.CNT_W(16)) bus ();
    if_fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    always #5 clk = ~clk;
    // imem[i] = 0xE0000000 + i, combinational read
    assign bus.imem_data = 32'hE000_0000 + (bus.imem_addr >> 2);
    typedef struct {
        logic        le, stall, br;
        logic [31:0] target, pc, instr, pc4;
        logic        valid;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[23];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid, input logic [15:0] cnt);
        chk({tag, " pc"}, bus.pc_out, pc);
        chk({tag, " imem_addr"}, bus.imem_addr, pc);
        chk({tag, " instr"}, bus.ifid_instr, instr);
        chk({tag, " pc4"}, bus.ifid_pc4, pc4);
        chk({tag, " valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
        chk({tag, " count"}, {16'd0, bus.fetch_count}, {16'd0, cnt});
    endtask
    task automatic drive(input logic le, input logic stall, input logic br, input logic [31:0] t);
        bus.le = le; bus.stall = stall; bus.br_taken = br; bus.br_target = t;
        @(posedge clk);
        #1;
    endtask
    initial begin
        vecs[0]  = '{1,0,0,32'h0,        32'h0,        32'h0,        32'h0,   0, 16'd0};
        vecs[1]  = '{1,0,0,32'h0,        32'h4,        32'hE0000000, 32'h4,   1, 16'd1};
        vecs[2]  = '{1,0,0,32'h0,        32'h8,        32'hE0000001, 32'h8,   1, 16'd2};
        vecs[3]  = '{1,0,0,32'h0,        32'hC,        32'hE0000002, 32'hC,   1, 16'd3};
        vecs[4]  = '{1,0,0,32'h0,        32'h10,       32'hE0000003, 32'h10,  1, 16'd4};
        vecs[5]  = '{1,0,0,32'h0,        32'h14,       32'hE0000004, 32'h14,  1, 16'd5};
        vecs[6]  = '{1,0,0,32'h0,        32'h18,       32'hE0000005, 32'h18,  1, 16'd6};
        vecs[7]  = '{1,1,0,32'h0,        32'h18,       32'hE0000005, 32'h18,  1, 16'd6};
        vecs[8]  = '{1,1,0,32'h0,        32'h18,       32'hE0000005, 32'h18,  1, 16'd6};
        vecs[9]  = '{1,0,0,32'h0,        32'h1C,       32'hE0000006, 32'h1C,  1, 16'd7};
        vecs[10] = '{1,0,1,32'h103,      32'h100,      32'h0,        32'h0,   0, 16'd7};
        vecs[11] = '{1,0,0,32'h0,        32'h104,      32'hE0000040, 32'h104, 1, 16'd8};
        vecs[12] = '{1,1,1,32'h200,      32'h104,      32'hE0000040, 32'h104, 1, 16'd8};
        vecs[13] = '{1,0,1,32'h200,      32'h200,      32'h0,        32'h0,   0, 16'd8};
        vecs[14] = '{1,0,0,32'h0,        32'h204,      32'hE0000080, 32'h204, 1, 16'd9};
        vecs[15] = '{1,0,1,32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,   0, 16'd9};
        vecs[16] = '{1,0,0,32'h0,        32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[17] = '{0,0,0,32'h0,        32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[18] = '{0,0,1,32'h40,       32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[19] = '{0,0,0,32'h0,        32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[20] = '{0,0,1,32'h40,       32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[21] = '{1,0,0,32'h0,        32'h0,        32'h1FFFFFFF, 32'h0,   1, 16'd10};
        vecs[22] = '{1,0,0,32'h0,        32'h4,        32'hE0000000, 32'h4,   1, 16'd11};
        bus.le = 1'b1; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk_all("reset_held", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].le, vecs[i].stall, vecs[i].br, vecs[i].target);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                    vecs[i].valid, vecs[i].cnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("boot_le0", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("boot_settle", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("boot_first", 32'h4, 32'hE0000000, 32'h4, 1'b1, 16'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
